// File: rtl/rggen_register_access_arbiter_pkg.sv
// Shared state type and helpers for the register access arbiter.
// Strobe expansion works on a fixed maximum width so one function serves every DATA_WIDTH up to 256.
package rggen_register_access_arbiter_pkg;

  localparam int MAX_DATA_WIDTH   = 256;
  localparam int MAX_STROBE_WIDTH = MAX_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPONSE
  } arbiter_state_e;

  function automatic int timeout_counter_width(input int timeout_cycles);
    int width;
    width = $clog2(timeout_cycles + 1);
    return (width < 1) ? 1 : width;
  endfunction

  function automatic logic [MAX_DATA_WIDTH-1:0] expand_strobe(
    input logic [MAX_STROBE_WIDTH-1:0] strobe
  );
    logic [MAX_DATA_WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_STROBE_WIDTH; i++) begin
      mask[i*8 +: 8] = {8{strobe[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/rggen_round_robin_arbiter.sv
// Combinational round-robin pick: the first request found searching upward
// from the requester after last_grant, wrapping around.
module rggen_round_robin_arbiter #(
  parameter int REQUESTERS  = 2,
  parameter int INDEX_WIDTH = 1
) (
  input  logic [REQUESTERS-1:0]  request,
  input  logic [INDEX_WIDTH-1:0] last_grant,
  output logic [REQUESTERS-1:0]  grant
);

  always_comb begin
    logic                   found;
    logic [INDEX_WIDTH-1:0] candidate;
    grant     = '0;
    found     = 1'b0;
    candidate = '0;
    for (int offset = 1; offset <= REQUESTERS; offset++) begin
      candidate = INDEX_WIDTH'((int'(last_grant) + offset) % REQUESTERS);
      if (!found && request[candidate]) begin
        grant[candidate] = 1'b1;
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rggen_register_access_arbiter.sv
// Shares one register-block access port between several hosts: round-robin
// accept, hold the access until the block completes (or times out), then return the response.
module rggen_register_access_arbiter
  import rggen_register_access_arbiter_pkg::*;
#(
  parameter int REQUESTERS     = 2,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [REQUESTERS-1:0]               req_valid,
  output logic [REQUESTERS-1:0]               req_ready,
  input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] req_address,
  input  logic [REQUESTERS-1:0]               req_write,
  input  logic [REQUESTERS*DATA_WIDTH-1:0]    req_write_data,
  input  logic [REQUESTERS*DATA_WIDTH/8-1:0]  req_strobe,
  output logic [REQUESTERS-1:0]               rsp_valid,
  input  logic [REQUESTERS-1:0]               rsp_ready,
  output logic [DATA_WIDTH-1:0]               rsp_read_data,
  output logic                                rsp_error,
  output logic                                access_valid,
  input  logic                                access_ready,
  output logic [ADDRESS_WIDTH-1:0]            access_address,
  output logic                                access_write,
  output logic [DATA_WIDTH-1:0]               access_write_data,
  output logic [DATA_WIDTH-1:0]               access_write_mask,
  input  logic [DATA_WIDTH-1:0]               access_read_data,
  input  logic                                access_error
);

  localparam int STROBE_WIDTH  = DATA_WIDTH / 8;
  localparam int INDEX_WIDTH   = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int COUNTER_WIDTH = timeout_counter_width(TIMEOUT_CYCLES);
  localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LAST =
    COUNTER_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [INDEX_WIDTH-1:0] INITIAL_GRANT = INDEX_WIDTH'(REQUESTERS - 1);

  arbiter_state_e           state_q, state_d;
  logic [INDEX_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [REQUESTERS-1:0]    grant_q, grant_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic                     write_q, write_d;
  logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
  logic [DATA_WIDTH-1:0]    write_mask_q, write_mask_d;
  logic [DATA_WIDTH-1:0]    read_data_q, read_data_d;
  logic                     error_q, error_d;
  logic [COUNTER_WIDTH-1:0] timeout_count_q, timeout_count_d;

  logic [REQUESTERS-1:0]    winner;
  logic [INDEX_WIDTH-1:0]   winner_index;
  logic [STROBE_WIDTH-1:0]  winner_strobe;
  logic                     timed_out;

  rggen_round_robin_arbiter #(
    .REQUESTERS  (REQUESTERS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_arbiter (
    .request    (req_valid),
    .last_grant (last_grant_q),
    .grant      (winner)
  );

  always_comb begin
    winner_index = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (winner[i]) begin
        winner_index = INDEX_WIDTH'(i);
      end
    end
  end

  assign winner_strobe = req_strobe[winner_index*STROBE_WIDTH +: STROBE_WIDTH];
  assign timed_out     = (TIMEOUT_CYCLES != 0) && (timeout_count_q == TIMEOUT_LAST);

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    grant_d         = grant_q;
    address_d       = address_q;
    write_d         = write_q;
    write_data_d    = write_data_q;
    write_mask_d    = write_mask_q;
    read_data_d     = read_data_q;
    error_d         = error_q;
    timeout_count_d = timeout_count_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          last_grant_d    = winner_index;
          grant_d         = winner;
          address_d       = req_address[winner_index*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          write_d         = req_write[winner_index];
          write_data_d    = req_write[winner_index]
                          ? req_write_data[winner_index*DATA_WIDTH +: DATA_WIDTH] : '0;
          write_mask_d    = req_write[winner_index]
                          ? DATA_WIDTH'(expand_strobe(MAX_STROBE_WIDTH'(winner_strobe))) : '0;
          read_data_d     = '0;
          error_d         = 1'b0;
          timeout_count_d = '0;
          state_d         = ACCESS;
        end
      end
      ACCESS: begin
        // A completion on the same edge as the timeout wins.
        if (access_ready) begin
          read_data_d = write_q ? '0 : access_read_data;
          error_d     = access_error;
          state_d     = RESPONSE;
        end else if (timed_out) begin
          read_data_d = '0;
          error_d     = 1'b1;
          state_d     = RESPONSE;
        end else if (TIMEOUT_CYCLES != 0) begin
          timeout_count_d = timeout_count_q + 1'b1;
        end
      end
      RESPONSE: begin
        if (|(rsp_ready & grant_q)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      last_grant_q    <= INITIAL_GRANT;
      grant_q         <= '0;
      address_q       <= '0;
      write_q         <= 1'b0;
      write_data_q    <= '0;
      write_mask_q    <= '0;
      read_data_q     <= '0;
      error_q         <= 1'b0;
      timeout_count_q <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      grant_q         <= grant_d;
      address_q       <= address_d;
      write_q         <= write_d;
      write_data_q    <= write_data_d;
      write_mask_q    <= write_mask_d;
      read_data_q     <= read_data_d;
      error_q         <= error_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign req_ready         = (state_q == IDLE && rst_n) ? winner : '0;
  assign access_valid      = (state_q == ACCESS);
  assign rsp_valid         = (state_q == RESPONSE) ? grant_q : '0;
  assign rsp_read_data     = read_data_q;
  assign rsp_error         = error_q;
  assign access_address    = address_q;
  assign access_write      = write_q;
  assign access_write_data = write_data_q;
  assign access_write_mask = write_mask_q;

  // A requester must hold valid and payload steady until it is accepted.
  for (genvar r = 0; r < REQUESTERS; r++) begin : g_request_stable
    a_request_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid[r] && !req_ready[r]) |=>
        (req_valid[r]
         && $stable(req_address[r*ADDRESS_WIDTH +: ADDRESS_WIDTH])
         && $stable(req_write[r])
         && $stable(req_write_data[r*DATA_WIDTH +: DATA_WIDTH])
         && $stable(req_strobe[r*STROBE_WIDTH +: STROBE_WIDTH])));
  end

endmodule

// File: tb/tb_rggen_register_access_arbiter.sv
// Self-checking bench: a register-block model and a response checker consume
// expected accesses/responses queued when each grant is predicted.
module tb_rggen_register_access_arbiter;

  localparam int REQUESTERS = 2;
  localparam int AW         = 8;
  localparam int DW         = 32;
  localparam int SW         = DW / 8;
  localparam int TIMEOUT    = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           req_valid, req_ready, req_write, rsp_valid, rsp_ready;
  logic [2*AW-1:0]      req_address;
  logic [2*DW-1:0]      req_write_data;
  logic [2*SW-1:0]      req_strobe;
  logic [DW-1:0]        rsp_read_data;
  logic                 rsp_error;
  logic                 access_valid, access_ready, access_write, access_error;
  logic [AW-1:0]        access_address;
  logic [DW-1:0]        access_write_data, access_write_mask, access_read_data;

  typedef struct {
    logic [7:0]  address;
    logic        write;
    logic [31:0] write_data;
    logic [31:0] write_mask;
    logic        stall;
    int          latency;
  } access_exp_t;

  typedef struct {
    int          requester;
    logic [31:0] read_data;
    logic        error;
    int          hold;
  } response_exp_t;

  access_exp_t   access_q[$];
  response_exp_t response_q[$];
  int            checks = 0;
  int            errors = 0;
  bit            response_busy = 1'b0;
  logic [7:0]    pend_address [2];
  logic          pend_write   [2];
  logic [31:0]   pend_data    [2];
  logic [3:0]    pend_strobe  [2];

  rggen_register_access_arbiter #(
    .REQUESTERS     (REQUESTERS),
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_address       (req_address),
    .req_write         (req_write),
    .req_write_data    (req_write_data),
    .req_strobe        (req_strobe),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_read_data     (rsp_read_data),
    .rsp_error         (rsp_error),
    .access_valid      (access_valid),
    .access_ready      (access_ready),
    .access_address    (access_address),
    .access_write      (access_write),
    .access_write_data (access_write_data),
    .access_write_mask (access_write_mask),
    .access_read_data  (access_read_data),
    .access_error      (access_error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] blockData(input logic [7:0] address);
    return (address == 8'h04) ? 32'hDEADBEEF : {4{address}};
  endfunction

  function automatic logic [31:0] strobeToMask(input logic [3:0] strobe);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) begin
      if (strobe[b]) mask[b*8 +: 8] = 8'hFF;
    end
    return mask;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int r, input logic [7:0] address, input logic write,
                               input logic [31:0] data, input logic [3:0] strobe);
    pend_address[r]             = address;
    pend_write[r]               = write;
    pend_data[r]                = data;
    pend_strobe[r]              = strobe;
    req_address[r*AW +: AW]     = address;
    req_write[r]                = write;
    req_write_data[r*DW +: DW]  = data;
    req_strobe[r*SW +: SW]      = strobe;
    req_valid[r]                = 1'b1;
  endtask

  // Waits for the predicted winner, queues what its access and response must look like.
  task automatic wait_grant(input int expected_r, input string tag, input int latency,
                            input int hold, input logic stall);
    int            winner;
    access_exp_t   acc;
    response_exp_t rsp;
    winner = -1;
    for (int c = 0; c < 64 && winner < 0; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (req_ready[i]) winner = i;
      end
    end
    checkOutput({tag, "_grant"}, 32'(winner), 32'(expected_r));
    if (winner >= 0) begin
      checkOutput({tag, "_ready_onehot"}, 32'($countones(req_ready)), 32'd1);
      acc.address    = pend_address[expected_r];
      acc.write      = pend_write[expected_r];
      acc.write_data = pend_write[expected_r] ? pend_data[expected_r] : 32'h0;
      acc.write_mask = pend_write[expected_r] ? strobeToMask(pend_strobe[expected_r]) : 32'h0;
      acc.stall      = stall;
      acc.latency    = latency;
      access_q.push_back(acc);
      rsp.requester  = expected_r;
      rsp.hold       = hold;
      rsp.error      = stall ? 1'b1 : (pend_address[expected_r] >= 8'hF0);
      rsp.read_data  = (stall || pend_write[expected_r]) ? 32'h0 : blockData(pend_address[expected_r]);
      response_q.push_back(rsp);
      @(posedge clk);
      #1;
      req_valid[winner] = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_access_valid"}, 32'(access_valid), 32'd1);
    end
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while ((response_q.size() != 0 || response_busy) && c < 200) begin
      @(negedge clk);
      c++;
    end
    checkOutput({tag, "_drained"}, 32'(response_q.size() + int'(response_busy)), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Register block model: checks the presented access every cycle, completes after its latency.
  initial begin
    access_exp_t current;
    bit          in_access;
    int          waited;
    int          cycles;
    in_access        = 1'b0;
    waited           = 0;
    cycles           = 0;
    current.address  = '0;
    current.write    = 1'b0;
    current.write_data = '0;
    current.write_mask = '0;
    current.stall    = 1'b0;
    current.latency  = 0;
    access_ready     = 1'b0;
    access_read_data = '0;
    access_error     = 1'b0;
    forever begin
      @(negedge clk);
      if (access_valid && rst_n) begin
        if (!in_access) begin
          in_access = 1'b1;
          waited    = 0;
          cycles    = 0;
          if (access_q.size() == 0) checkOutput("access_unexpected", 32'(access_valid), 32'd0);
          else current = access_q.pop_front();
        end
        cycles++;
        checkOutput("access_address", 32'(access_address), 32'(current.address));
        checkOutput("access_write", 32'(access_write), 32'(current.write));
        checkOutput("access_write_data", access_write_data, current.write_data);
        checkOutput("access_write_mask", access_write_mask, current.write_mask);
        if (!current.stall && waited == current.latency) begin
          access_ready     = 1'b1;
          access_read_data = blockData(current.address);
          access_error     = (current.address >= 8'hF0);
        end else begin
          access_ready     = 1'b0;
          access_read_data = 32'hBADC0DE5;
          access_error     = 1'b0;
          waited++;
        end
      end else begin
        if (in_access && rst_n && current.stall) begin
          checkOutput("timeout_cycles", 32'(cycles), 32'(TIMEOUT));
        end
        in_access        = 1'b0;
        access_ready     = 1'b0;
        access_read_data = '0;
        access_error     = 1'b0;
      end
    end
  end

  // Response checker: holds off rsp_ready for the requested cycles while poking the other requester's ready.
  initial begin
    response_exp_t expected;
    logic [1:0]    onehot;
    rsp_ready = '0;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid != '0) begin
        response_busy = 1'b1;
        if (response_q.size() == 0) begin
          checkOutput("response_unexpected", 32'(rsp_valid), 32'd0);
          rsp_ready = rsp_valid;
        end else begin
          expected = response_q.pop_front();
          onehot   = 2'b01 << expected.requester;
          for (int h = 0; h <= expected.hold; h++) begin
            if (h > 0) @(negedge clk);
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(onehot));
            checkOutput("rsp_read_data", rsp_read_data, expected.read_data);
            checkOutput("rsp_error", 32'(rsp_error), 32'(expected.error));
            checkOutput("rsp_access_idle", 32'(access_valid), 32'd0);
            checkOutput("rsp_no_grant", 32'(req_ready), 32'd0);
            rsp_ready = (h < expected.hold) ? ~onehot : onehot;
          end
        end
        @(posedge clk);
        #1;
        rsp_ready     = '0;
        response_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    req_valid      = '0;
    req_write      = '0;
    req_address    = '0;
    req_write_data = '0;
    req_strobe     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_access_valid", 32'(access_valid), 32'd0);
    checkOutput("reset_access_write", 32'(access_write), 32'd0);
    checkOutput("reset_access_address", 32'(access_address), 32'd0);
    checkOutput("reset_write_data", access_write_data, 32'd0);
    checkOutput("reset_write_mask", access_write_mask, 32'd0);
    checkOutput("reset_read_data", rsp_read_data, 32'd0);
    checkOutput("reset_rsp_error", 32'(rsp_error), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    applyStimulus(0, 8'h04, 1'b0, 32'h0, 4'h0);
    wait_grant(0, "single_read", 2, 0, 1'b0);
    wait_done("single_read");

    applyStimulus(0, 8'h10, 1'b1, 32'h12345678, 4'b0101);
    wait_grant(0, "write_mask", 0, 0, 1'b0);
    wait_done("write_mask");

    applyStimulus(1, 8'h08, 1'b0, 32'h0, 4'h0);
    wait_grant(1, "read_r1", 1, 0, 1'b0);
    wait_done("read_r1");

    // Both requesters stay busy; grants must alternate starting from requester 0.
    applyStimulus(0, 8'h20, 1'b0, 32'h0, 4'h0);
    applyStimulus(1, 8'h21, 1'b0, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      wait_grant(k % 2, "round_robin", k % 3, 0, 1'b0);
      if (k < 2) applyStimulus(k % 2, 8'(8'h22 + k), 1'b1, 32'hA5A50000 + k, 4'b1100);
    end
    wait_done("round_robin");

    applyStimulus(0, 8'hF4, 1'b0, 32'h0, 4'h0);
    wait_grant(0, "error_backpressure", 1, 3, 1'b0);
    applyStimulus(1, 8'h0C, 1'b0, 32'h0, 4'h0);
    wait_grant(1, "after_backpressure", 0, 0, 1'b0);
    wait_done("after_backpressure");

    applyStimulus(0, 8'h30, 1'b0, 32'h0, 4'h0);
    wait_grant(0, "timeout", 0, 0, 1'b1);
    wait_done("timeout");

    applyStimulus(0, 8'h40, 1'b0, 32'h0, 4'h0);
    wait_grant(0, "pre_reset", 0, 0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_reset_access_valid", 32'(access_valid), 32'd0);
    checkOutput("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    access_q.delete();
    response_q.delete();
    applyStimulus(0, 8'h44, 1'b0, 32'h0, 4'h0);
    applyStimulus(1, 8'h48, 1'b1, 32'h0BADF00D, 4'b1111);
    wait_grant(0, "post_reset_first", 0, 0, 1'b0);
    wait_grant(1, "post_reset_second", 1, 0, 1'b0);
    wait_done("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
